// File: rtl/axi4_sub_mem_pkg.sv
// Shared AXI4 channel types, burst/response encodings and helpers for the memory subordinate.
package axi4_sub_mem_pkg;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_R_W = 3;
  localparam int AXI_ID_W_W = 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W_W-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_R_W-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_W_W-1:0] id;
    logic [1:0]            resp;
    logic                  user;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_R_W-1:0] id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic                  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_chan_t  r;
    logic     r_valid;
  } axi_resp_t;

  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction
endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts plus a flag for
// burst shapes this subordinate refuses.
module axi4_burst_addr #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_illegal
);
  import axi4_sub_mem_pkg::*;

  logic [ADDR_WIDTH-1:0] w_beat_bytes;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_block;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_incr_next;
  logic                  w_wrap_ok;

  always_comb begin
    w_beat_bytes = ADDR_WIDTH'(1) << i_size;
    w_aligned    = i_addr & ~(w_beat_bytes - ADDR_WIDTH'(1));
    w_block      = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
    w_base       = i_addr & ~(w_block - ADDR_WIDTH'(1));
    w_incr_next  = w_aligned + w_beat_bytes;
    w_wrap_ok    = wrap_len_legal(i_len);

    // Wrap block is a power of two, so masking the incremented offset folds it back to base.
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = w_wrap_ok ? (w_base | (w_incr_next & (w_block - ADDR_WIDTH'(1))))
                                           : w_incr_next;
      default:     o_next_addr = w_incr_next;
    endcase

    o_illegal = (i_burst == 2'b11) ||
                ((i_burst == BURST_WRAP) && !w_wrap_ok) ||
                (w_beat_bytes > ADDR_WIDTH'(DATA_WIDTH / 8));
  end
endmodule

// File: rtl/axi4_sub_mem.sv
// AXI4 subordinate backed by a flop-array memory; independent single-burst
// write (AW/W/B) and read (AR/R) engines.
module axi4_sub_mem #(
  parameter int  ADDR_WIDTH = 64,
  parameter int  DATA_WIDTH = 64,
  parameter int  ID_R_WIDTH = 3,
  parameter int  ID_W_WIDTH = 2,
  parameter int  MEM_BYTES  = 4096,
  parameter type axi_req_t  = axi4_sub_mem_pkg::axi_req_t,
  parameter type axi_resp_t = axi4_sub_mem_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      arst_ni,
  input  axi_req_t  req_i,
  output axi_resp_t resp_o
);
  import axi4_sub_mem_pkg::*;

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(STRB_W);
  localparam int IDX_HI    = $clog2(MEM_BYTES) - 1;
  localparam int MEM_WORDS = MEM_BYTES / STRB_W;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Holds readies low until the first edge after reset release.
  logic                  r_live;
  logic [1:0]            r_wstate;
  logic [ID_W_WIDTH-1:0] r_wid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic                  r_werr;
  logic [0:0]            r_rstate;
  logic [ID_R_WIDTH-1:0] r_rid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;

  logic [ADDR_WIDTH-1:0] w_wnext, w_rnext;
  logic                  w_willegal, w_rillegal;
  logic                  w_woob, w_roob, w_wlast_beat, w_rlast_beat;
  logic                  w_whs, w_wbeat_err, w_rerr;
  logic [DATA_WIDTH-1:0] w_rdata;

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_waddr (
    .i_addr(r_waddr), .i_len(r_wlen), .i_size(r_wsize), .i_burst(r_wburst),
    .o_next_addr(w_wnext), .o_illegal(w_willegal)
  );

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_raddr (
    .i_addr(r_raddr), .i_len(r_rlen), .i_size(r_rsize), .i_burst(r_rburst),
    .o_next_addr(w_rnext), .o_illegal(w_rillegal)
  );

  assign w_woob       = r_waddr >= ADDR_WIDTH'(MEM_BYTES);
  assign w_roob       = r_raddr >= ADDR_WIDTH'(MEM_BYTES);
  assign w_wlast_beat = r_wcnt == r_wlen;
  assign w_rlast_beat = r_rcnt == r_rlen;
  assign w_whs        = (r_wstate == W_DATA) && req_i.w_valid;
  assign w_wbeat_err  = w_willegal || w_woob || (req_i.w.last != w_wlast_beat);
  assign w_rerr       = w_rillegal || w_roob;
  assign w_rdata      = w_rerr ? '0 : mem[r_raddr[IDX_HI:OFF_W]];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_live   <= 1'b0;
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_wstate)
        W_IDLE: if (r_live && req_i.aw_valid) begin
          r_wid    <= req_i.aw.id;
          r_waddr  <= req_i.aw.addr;
          r_wlen   <= req_i.aw.len;
          r_wsize  <= req_i.aw.size;
          r_wburst <= req_i.aw.burst;
          r_wcnt   <= '0;
          r_werr   <= 1'b0;
          r_wstate <= W_DATA;
        end
        W_DATA: if (w_whs) begin
          r_waddr <= w_wnext;
          r_wcnt  <= r_wcnt + 8'd1;
          r_werr  <= r_werr || w_wbeat_err;
          if (w_wlast_beat) r_wstate <= W_RESP;
        end
        W_RESP: if (req_i.b_ready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (r_live && req_i.ar_valid) begin
          r_rid    <= req_i.ar.id;
          r_raddr  <= req_i.ar.addr;
          r_rlen   <= req_i.ar.len;
          r_rsize  <= req_i.ar.size;
          r_rburst <= req_i.ar.burst;
          r_rcnt   <= '0;
          r_rstate <= R_DATA;
        end
        default: if (req_i.r_ready) begin
          r_raddr <= w_rnext;
          r_rcnt  <= r_rcnt + 8'd1;
          if (w_rlast_beat) r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  // Memory is deliberately left out of reset; out-of-range beats never write.
  always_ff @(posedge clk_i) begin
    if (w_whs && !w_woob) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (req_i.w.strb[i]) mem[r_waddr[IDX_HI:OFF_W]][i*8 +: 8] <= req_i.w.data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = r_live && (r_wstate == W_IDLE);
    resp_o.w_ready  = r_wstate == W_DATA;
    resp_o.b_valid  = r_wstate == W_RESP;
    resp_o.ar_ready = r_live && (r_rstate == R_IDLE);
    resp_o.r_valid  = r_rstate == R_DATA;
    if (r_wstate == W_RESP) begin
      resp_o.b.id   = r_wid;
      resp_o.b.resp = r_werr ? RESP_SLVERR : RESP_OKAY;
    end
    if (r_rstate == R_DATA) begin
      resp_o.r.id   = r_rid;
      resp_o.r.data = w_rdata;
      resp_o.r.resp = w_rerr ? RESP_SLVERR : RESP_OKAY;
      resp_o.r.last = w_rlast_beat;
    end
  end
endmodule
